// File: rtl/param_barrel_shift_seq.sv
// Multi-cycle shifter with five modes and configurable width and bits-per-cycle step.
// A start/busy/done handshake is provided, and enb stalls an operation in progress.
module param_barrel_shift_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 16,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             start,
  input  logic [WIDTH-1:0] DATA,
  input  logic [AMT_W-1:0] SHIFT_VALUE,
  input  logic [2:0]       MODE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Reg_Shift_Out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int LW = $clog2(WIDTH);
  localparam int XW = (AMT_W > CW) ? AMT_W : CW;

  localparam logic [2:0] M_LSL = 3'b000;
  localparam logic [2:0] M_LSR = 3'b001;
  localparam logic [2:0] M_ASR = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0 || STEP < 1 || STEP > WIDTH) begin : g_param_check
    $error("param_barrel_shift_seq: WIDTH must be a power of two >= 4 and STEP in 1..WIDTH");
  end

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [XW-1:0]    amt_x;
  logic [CW-1:0]    n_in;
  logic [CW-1:0]    step_amt;
  logic [WIDTH-1:0] shifted;

  // Amount is widened before comparing so large values clamp instead of wrapping
  assign amt_x = XW'(SHIFT_VALUE);

  always_comb begin
    n_in = '0;
    case (MODE)
      M_LSL, M_LSR, M_ASR: n_in = (amt_x >= XW'(WIDTH)) ? CW'(WIDTH) : CW'(amt_x);
      M_ROL, M_ROR:        n_in = CW'(amt_x[LW-1:0]);
      default:             n_in = '0;
    endcase
  end

  assign step_amt = (count_q < CW'(STEP)) ? count_q : CW'(STEP);

  always_comb begin
    shifted = work_q;
    case (mode_q)
      M_LSL:   shifted = work_q << step_amt;
      M_LSR:   shifted = work_q >> step_amt;
      M_ASR:   shifted = $signed(work_q) >>> step_amt;
      M_ROL:   shifted = (work_q << step_amt) | (work_q >> (CW'(WIDTH) - step_amt));
      M_ROR:   shifted = (work_q >> step_amt) | (work_q << (CW'(WIDTH) - step_amt));
      default: shifted = work_q;
    endcase
  end

  // Zero-length operations complete straight from IDLE without entering SHIFT
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    mode_d   = mode_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_in == '0) begin
            result_d = DATA;
            done_d   = 1'b1;
          end else begin
            work_d  = DATA;
            count_d = n_in;
            mode_d  = MODE;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (enb) begin
          work_d  = shifted;
          count_d = count_q - step_amt;
          if (count_q == step_amt) begin
            result_d = shifted;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      count_q  <= '0;
      mode_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy          = (state_q == SHIFT);
  assign done          = done_q;
  assign Reg_Shift_Out = result_q;

endmodule

// File: tb/tb_param_barrel_shift_seq.sv
// Bench for param_barrel_shift_seq: directed and random operations on a STEP=1 and a STEP=4 instance.
// Expected results come from a bit-position reference model.
module tb_param_barrel_shift_seq;

  logic        clk;
  logic        rst;
  logic        a_enb, a_start, a_busy, a_done;
  logic [15:0] a_data, a_out;
  logic [19:0] a_amt;
  logic [2:0]  a_mode;
  logic        b_enb, b_start, b_busy, b_done;
  logic [15:0] b_data, b_out;
  logic [15:0] b_amt;
  logic [2:0]  b_mode;

  int          num_compared = 0;
  int          num_mismatched = 0;
  logic [15:0] last_a = '0;
  logic [15:0] last_b = '0;

  param_barrel_shift_seq #(.WIDTH(16), .AMT_W(20), .STEP(1)) dut_a (
    .clk(clk), .rst(rst), .enb(a_enb), .start(a_start), .DATA(a_data),
    .SHIFT_VALUE(a_amt), .MODE(a_mode), .busy(a_busy), .done(a_done),
    .Reg_Shift_Out(a_out)
  );

  param_barrel_shift_seq #(.WIDTH(16), .AMT_W(16), .STEP(4)) dut_b (
    .clk(clk), .rst(rst), .enb(b_enb), .start(b_start), .DATA(b_data),
    .SHIFT_VALUE(b_amt), .MODE(b_mode), .busy(b_busy), .done(b_done),
    .Reg_Shift_Out(b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_compared++;
    assert (obs === exp) else begin
      num_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Each result bit is looked up from the source bit it must come from
  function automatic logic [15:0] ref_result(input logic [15:0] d, input int n, input logic [2:0] mode);
    logic [15:0] r;
    int src;
    r = d;
    for (int i = 0; i < 16; i++) begin
      case (mode)
        3'd0: begin src = i - n; r[i] = (src >= 0) ? d[src] : 1'b0; end
        3'd1: begin src = i + n; r[i] = (src < 16) ? d[src] : 1'b0; end
        3'd2: begin src = i + n; r[i] = (src < 16) ? d[src] : d[15]; end
        3'd3: r[i] = d[(i - n + 16) % 16];
        3'd4: r[i] = d[(i + n) % 16];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  function automatic int eff_amount(input logic [19:0] amt, input logic [2:0] mode);
    if (mode <= 3'd2) return (amt >= 20'd16) ? 16 : int'(amt);
    if (mode <= 3'd4) return int'(amt % 20'd16);
    return 0;
  endfunction

  function automatic logic get_done(input int inst);
    return (inst == 0) ? a_done : b_done;
  endfunction

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? a_busy : b_busy;
  endfunction

  function automatic logic [15:0] get_out(input int inst);
    return (inst == 0) ? a_out : b_out;
  endfunction

  task automatic apply_stimulus(input int inst, input logic [15:0] data, input logic [19:0] amt,
                                input logic [2:0] mode);
    if (inst == 0) begin
      a_start = 1'b1; a_data = data; a_amt = amt; a_mode = mode;
    end else begin
      b_start = 1'b1; b_data = data; b_amt = amt[15:0]; b_mode = mode;
    end
  endtask

  // Operands are scrambled after acceptance since they must not matter any more
  task automatic release_start(input int inst);
    if (inst == 0) begin
      a_start = 1'b0; a_data = 16'($urandom); a_amt = 20'($urandom); a_mode = 3'($urandom);
    end else begin
      b_start = 1'b0; b_data = 16'($urandom); b_amt = 16'($urandom); b_mode = 3'($urandom);
    end
  endtask

  task automatic run_op(input int inst, input logic [15:0] data, input logic [19:0] amt,
                        input logic [2:0] mode, input logic [15:0] exp_res, input int exp_lat,
                        input string tag);
    logic [15:0] last;
    int cyc;
    last = (inst == 0) ? last_a : last_b;
    cyc = 0;
    apply_stimulus(inst, data, amt, mode);
    tick();
    release_start(inst);
    check_output({tag, "/busy_after_k0"}, 32'(get_busy(inst)), 32'(exp_lat > 0));
    while (get_done(inst) !== 1'b1 && cyc < exp_lat + 8) begin
      check_output({tag, "/hold_out"}, 32'(get_out(inst)), 32'(last));
      tick();
      cyc++;
    end
    check_output({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
    check_output({tag, "/done"}, 32'(get_done(inst)), 32'd1);
    check_output({tag, "/busy_at_done"}, 32'(get_busy(inst)), 32'd0);
    check_output({tag, "/result"}, 32'(get_out(inst)), 32'(exp_res));
    if (inst == 0) last_a = exp_res; else last_b = exp_res;
    tick();
    check_output({tag, "/done_clear"}, 32'(get_done(inst)), 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    a_enb = 1'b1; a_start = 1'b0; a_data = '0; a_amt = '0; a_mode = '0;
    b_enb = 1'b1; b_start = 1'b0; b_data = '0; b_amt = '0; b_mode = '0;
    tick();
    tick();
    check_output("reset/a_busy", 32'(a_busy), 32'd0);
    check_output("reset/a_done", 32'(a_done), 32'd0);
    check_output("reset/a_out", 32'(a_out), 32'd0);
    check_output("reset/b_busy", 32'(b_busy), 32'd0);
    check_output("reset/b_done", 32'(b_done), 32'd0);
    check_output("reset/b_out", 32'(b_out), 32'd0);
    rst = 1'b1;
    tick();

    run_op(0, 16'h0008, 20'd2, 3'd0, 16'h0020, 2, "lsl_2");
    run_op(0, 16'h8000, 20'd20, 3'd2, 16'hFFFF, 16, "asr_clamp");
    run_op(0, 16'h8000, 20'd20, 3'd1, 16'h0000, 16, "lsr_clamp");
    run_op(0, 16'h8000, 20'h10000, 3'd2, 16'hFFFF, 16, "asr_wide_amt");
    run_op(0, 16'h8001, 20'd17, 3'd3, 16'h0003, 1, "rol_17");
    run_op(0, 16'h8001, 20'd16, 3'd4, 16'h8001, 0, "ror_16");
    run_op(0, 16'h1234, 20'd7, 3'd5, 16'h1234, 0, "reserved");
    run_op(1, 16'hA5C3, 20'd16, 3'd3, 16'hA5C3, 0, "b_rol_16");

    // Stall: one shift, three enb-low cycles with two ignored start pulses
    apply_stimulus(0, 16'h00F0, 20'd4, 3'd1);
    tick();
    release_start(0);
    tick();
    a_enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_start = (i < 2);
      a_data = 16'($urandom);
      a_amt = 20'd1;
      a_mode = 3'd0;
      tick();
      check_output("stall/busy", 32'(a_busy), 32'd1);
    end
    a_start = 1'b0;
    a_enb = 1'b1;
    cyc = 0;
    while (a_done !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    check_output("stall/remaining", 32'(cyc), 32'd3);
    check_output("stall/result", 32'(a_out), 32'h000F);
    last_a = 16'h000F;
    tick();
    check_output("stall/done_clear", 32'(a_done), 32'd0);
    check_output("stall/no_extra_op", 32'(a_busy), 32'd0);

    // Back-to-back on the STEP=4 instance: 4+2 bits, then a new start in the done cycle
    apply_stimulus(1, 16'h0001, 20'd6, 3'd0);
    tick();
    release_start(1);
    check_output("b2b/busy1", 32'(b_busy), 32'd1);
    tick();
    check_output("b2b/not_done", 32'(b_done), 32'd0);
    tick();
    check_output("b2b/done", 32'(b_done), 32'd1);
    check_output("b2b/result1", 32'(b_out), 32'h0040);
    apply_stimulus(1, 16'h00F0, 20'd4, 3'd4);
    tick();
    release_start(1);
    check_output("b2b/busy2", 32'(b_busy), 32'd1);
    check_output("b2b/done_clear", 32'(b_done), 32'd0);
    check_output("b2b/hold", 32'(b_out), 32'h0040);
    tick();
    check_output("b2b/done2", 32'(b_done), 32'd1);
    check_output("b2b/result2", 32'(b_out), 32'h000F);
    last_b = 16'h000F;
    tick();

    // Random operations on both instances against the reference model
    for (int k = 0; k < 30; k++) begin
      for (int inst = 0; inst < 2; inst++) begin
        logic [15:0] d;
        logic [19:0] amt;
        logic [2:0]  m;
        int n;
        int stp;
        d = 16'($urandom);
        amt = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'($urandom_range(0, 40));
        if (inst == 1) amt = {4'b0, amt[15:0]};
        m = 3'($urandom_range(0, 7));
        n = eff_amount(amt, m);
        stp = (inst == 0) ? 1 : 4;
        run_op(inst, d, amt, m, ref_result(d, n, m), (n + stp - 1) / stp,
               $sformatf("rand%0d_%0d", k, inst));
      end
    end

    // Asynchronous reset in the middle of a shift
    apply_stimulus(0, 16'h0001, 20'd10, 3'd0);
    tick();
    release_start(0);
    tick();
    #3;
    rst = 1'b0;
    #1;
    check_output("arst/busy", 32'(a_busy), 32'd0);
    check_output("arst/done", 32'(a_done), 32'd0);
    check_output("arst/out", 32'(a_out), 32'd0);
    check_output("arst/b_out", 32'(b_out), 32'd0);
    tick();
    tick();
    check_output("arst/no_done", 32'(a_done), 32'd0);
    rst = 1'b1;
    last_a = '0;
    last_b = '0;
    tick();
    run_op(0, 16'h0001, 20'd1, 3'd0, 16'h0002, 1, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
